// File: rtl/store_queue_if.sv
// Store queue bus bundle: allocation, exec writeback, commit/squash and dcache drain.
// Load-forwarding signals exist only when STORE_QUEUE_FWD_EN is defined.
interface store_queue_if #(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned ENQ_WIDTH = 4,
   parameter int unsigned ADDR_W    = 64,
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned ROB_IDX_W = 6
);
   localparam int unsigned SQ_W   = $clog2(DEPTH) + 1;
   localparam int unsigned RB_W   = ROB_IDX_W + 1;
   localparam int unsigned MASK_W = DATA_W / 8;

   logic                              o_can_enq;
   logic                              i_enq_vld;
   logic [ENQ_WIDTH-1:0]              i_enq_req;
   logic [ENQ_WIDTH-1:0][RB_W-1:0]    i_enq_robIdx;
   logic [ENQ_WIDTH-1:0][SQ_W-1:0]    o_alloc_sqIdx;

   logic                              i_exe_vld;
   logic [SQ_W-1:0]                   i_exe_sqIdx;
   logic [ADDR_W-1:0]                 i_exe_addr;
   logic [DATA_W-1:0]                 i_exe_data;
   logic [MASK_W-1:0]                 i_exe_mask;

   logic                              i_commit_vld;
   logic [RB_W-1:0]                   i_committed_robIdx;
   logic                              i_squash_vld;

   logic                              o_dc_req_vld;
   logic [ADDR_W-1:0]                 o_dc_addr;
   logic [DATA_W-1:0]                 o_dc_data;
   logic [MASK_W-1:0]                 o_dc_mask;
   logic                              i_dc_req_rdy;
   logic                              o_empty;

`ifdef STORE_QUEUE_FWD_EN
   logic                              i_ld_vld;
   logic [ADDR_W-1:0]                 i_ld_addr;
   logic [RB_W-1:0]                   i_ld_robIdx;
   logic                              o_fwd_hit;
   logic [DATA_W-1:0]                 o_fwd_data;
   logic [MASK_W-1:0]                 o_fwd_mask;
`endif

   modport master (
      input  o_can_enq, o_alloc_sqIdx, o_dc_req_vld, o_dc_addr, o_dc_data, o_dc_mask, o_empty,
`ifdef STORE_QUEUE_FWD_EN
      input  o_fwd_hit, o_fwd_data, o_fwd_mask,
      output i_ld_vld, i_ld_addr, i_ld_robIdx,
`endif
      output i_enq_vld, i_enq_req, i_enq_robIdx,
      output i_exe_vld, i_exe_sqIdx, i_exe_addr, i_exe_data, i_exe_mask,
      output i_commit_vld, i_committed_robIdx, i_squash_vld, i_dc_req_rdy
   );

   modport slave (
      output o_can_enq, o_alloc_sqIdx, o_dc_req_vld, o_dc_addr, o_dc_data, o_dc_mask, o_empty,
`ifdef STORE_QUEUE_FWD_EN
      output o_fwd_hit, o_fwd_data, o_fwd_mask,
      input  i_ld_vld, i_ld_addr, i_ld_robIdx,
`endif
      input  i_enq_vld, i_enq_req, i_enq_robIdx,
      input  i_exe_vld, i_exe_sqIdx, i_exe_addr, i_exe_data, i_exe_mask,
      input  i_commit_vld, i_committed_robIdx, i_squash_vld, i_dc_req_rdy
   );
endinterface

// File: rtl/store_queue.sv
// Program-ordered store queue: allocate, exec writeback, commit, in-order dcache drain.
// Optional load forwarding is built when STORE_QUEUE_FWD_EN is defined.
module store_queue #(
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned ENQ_WIDTH    = 4,
   parameter int unsigned COMMIT_WIDTH = 4,
   parameter int unsigned ADDR_W       = 64,
   parameter int unsigned DATA_W       = 64,
   parameter int unsigned ROB_IDX_W    = 6
) (
   input  logic         clk,
   input  logic         rst,
   store_queue_if.slave bus
);
   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam int unsigned SQ_W   = IDX_W + 1;
   localparam int unsigned RB_W   = ROB_IDX_W + 1;
   localparam int unsigned MASK_W = DATA_W / 8;
   localparam logic [SQ_W:0] DEPTH_C = (SQ_W+1)'(DEPTH);
   localparam logic [SQ_W:0] ENQ_C   = (SQ_W+1)'(ENQ_WIDTH);

   typedef logic [RB_W-1:0] rob_t;

   logic [SQ_W-1:0]   head, cmt, tail;
   logic [SQ_W-1:0]   head_nxt, cmt_nxt, tail_nxt;
   logic [SQ_W-1:0]   occ, pend_cnt, cmt_adv, enq_cnt, exe_off;
   logic [SQ_W:0]     free_cnt;
   logic [IDX_W-1:0]  cidx, exe_idx;
   logic [IDX_W-1:0]  alloc_idx [ENQ_WIDTH];
   logic              run, cmt_all_done, enq_fire, exe_ok, drain_fire, can_enq;

   rob_t              ent_rob  [DEPTH];
   logic [ADDR_W-1:0] ent_addr [DEPTH];
   logic [DATA_W-1:0] ent_data [DEPTH];
   logic [MASK_W-1:0] ent_mask [DEPTH];
   logic [DEPTH-1:0]  exe_done;

   function automatic logic older_eq(rob_t a, rob_t b);
      if (a[RB_W-1] == b[RB_W-1])
         return a[RB_W-2:0] <= b[RB_W-2:0];
      return a[RB_W-2:0] > b[RB_W-2:0];
   endfunction

   assign occ      = tail - head;
   assign free_cnt = DEPTH_C - {1'b0, occ};
   assign can_enq  = free_cnt >= ENQ_C;
   assign pend_cnt = tail - cmt;

   // Commit walks at most COMMIT_WIDTH uncommitted entries and stops at the first younger one.
   always_comb begin
      cmt_adv      = '0;
      run          = 1'b1;
      cmt_all_done = 1'b1;
      cidx         = '0;
      for (int unsigned j = 0; j < COMMIT_WIDTH; j++) begin
         cidx = cmt[IDX_W-1:0] + IDX_W'(j);
         if (run && bus.i_commit_vld && (SQ_W'(j) < pend_cnt) &&
             older_eq(ent_rob[cidx], bus.i_committed_robIdx)) begin
            cmt_adv = cmt_adv + SQ_W'(1);
            if (!exe_done[cidx])
               cmt_all_done = 1'b0;
         end else begin
            run = 1'b0;
         end
      end
      cmt_nxt = cmt + cmt_adv;
   end

   assign enq_fire   = can_enq && bus.i_enq_vld && !bus.i_squash_vld;
   assign enq_cnt    = SQ_W'($countones(bus.i_enq_req));
   assign exe_off    = bus.i_exe_sqIdx - cmt;
   assign exe_ok     = bus.i_exe_vld && !bus.i_squash_vld && (exe_off < pend_cnt);
   assign exe_idx    = bus.i_exe_sqIdx[IDX_W-1:0];
   assign drain_fire = bus.o_dc_req_vld && bus.i_dc_req_rdy;

   always_comb begin
      head_nxt = drain_fire ? head + SQ_W'(1) : head;
      if (bus.i_squash_vld)
         tail_nxt = cmt_nxt;
      else if (enq_fire)
         tail_nxt = tail + enq_cnt;
      else
         tail_nxt = tail;
   end

   always_comb begin
      for (int unsigned k = 0; k < ENQ_WIDTH; k++) begin
         bus.o_alloc_sqIdx[k] = tail + SQ_W'(k);
         alloc_idx[k]         = tail[IDX_W-1:0] + IDX_W'(k);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head     <= '0;
         cmt      <= '0;
         tail     <= '0;
         exe_done <= '0;
      end else begin
         head <= head_nxt;
         cmt  <= cmt_nxt;
         tail <= tail_nxt;
         if (exe_ok)
            exe_done[exe_idx] <= 1'b1;
         if (enq_fire)
            for (int unsigned k = 0; k < ENQ_WIDTH; k++)
               if (bus.i_enq_req[k])
                  exe_done[alloc_idx[k]] <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (exe_ok) begin
         ent_addr[exe_idx] <= bus.i_exe_addr;
         ent_data[exe_idx] <= bus.i_exe_data;
         ent_mask[exe_idx] <= bus.i_exe_mask;
      end
      if (enq_fire)
         for (int unsigned k = 0; k < ENQ_WIDTH; k++)
            if (bus.i_enq_req[k])
               ent_rob[alloc_idx[k]] <= bus.i_enq_robIdx[k];
   end

   // A store may only retire once its address and data have been written back.
   always_ff @(posedge clk) begin
      if (!rst)
         commit_needs_exe: assert (cmt_all_done);
   end

   assign bus.o_can_enq    = can_enq;
   assign bus.o_empty      = (head == tail);
   assign bus.o_dc_req_vld = (head != cmt);
   assign bus.o_dc_addr    = ent_addr[head[IDX_W-1:0]];
   assign bus.o_dc_data    = ent_data[head[IDX_W-1:0]];
   assign bus.o_dc_mask    = ent_mask[head[IDX_W-1:0]];

`ifdef STORE_QUEUE_FWD_EN
   logic [IDX_W-1:0] fidx;

   // Scan oldest to youngest so the youngest qualifying store wins.
   always_comb begin
      bus.o_fwd_hit  = 1'b0;
      bus.o_fwd_data = '0;
      bus.o_fwd_mask = '0;
      fidx           = '0;
      for (int unsigned o = 0; o < DEPTH; o++) begin
         fidx = head[IDX_W-1:0] + IDX_W'(o);
         if (bus.i_ld_vld && (SQ_W'(o) < occ) && exe_done[fidx] &&
             older_eq(ent_rob[fidx], bus.i_ld_robIdx) && (ent_rob[fidx] != bus.i_ld_robIdx) &&
             (ent_addr[fidx][ADDR_W-1:3] == bus.i_ld_addr[ADDR_W-1:3])) begin
            bus.o_fwd_hit  = 1'b1;
            bus.o_fwd_data = ent_data[fidx];
            bus.o_fwd_mask = ent_mask[fidx];
         end
      end
   end
`endif
endmodule

// File: tb/tb_store_queue.sv
// Self-checking bench for store_queue: vector table plus scoreboarded multi-cycle sequences.
// Build with STORE_QUEUE_FWD_EN defined to also exercise load forwarding.
module tb_store_queue;
   localparam int DEPTH = 16;
   localparam int ENQW  = 4;

   typedef struct {
      logic [6:0]  rob;
      logic [4:0]  sq;
      logic [63:0] addr;
      logic [63:0] data;
      logic [7:0]  mask;
      bit          written;
   } st_t;

   typedef struct {
      logic [3:0] req;
      bit         exe;
      bit         cmt;
      logic [6:0] crob;
      bit         rdy;
      bit         e_can;
      bit         e_empty;
      bit         e_vld;
   } vec_t;

   logic clk;
   logic rst;

   store_queue_if #(.DEPTH(16), .ENQ_WIDTH(4), .ADDR_W(64), .DATA_W(64), .ROB_IDX_W(6)) bus ();

   store_queue #(
      .DEPTH(16), .ENQ_WIDTH(4), .COMMIT_WIDTH(4), .ADDR_W(64), .DATA_W(64), .ROB_IDX_W(6)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   st_t         pend[$];
   st_t         expq[$];
   logic [4:0]  m_tail;
   logic [6:0]  next_rob;
   int unsigned serial;
   bit          s_can, s_empty, s_vld;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   function automatic bit older_eq(logic [6:0] a, logic [6:0] b);
      if (a[6] == b[6])
         return a[5:0] <= b[5:0];
      return a[5:0] > b[5:0];
   endfunction

   function automatic bit has_unwritten();
      foreach (pend[i])
         if (!pend[i].written)
            return 1'b1;
      return 1'b0;
   endfunction

   task automatic clear_inputs();
      bus.i_enq_vld          = 1'b0;
      bus.i_enq_req          = '0;
      bus.i_enq_robIdx       = '0;
      bus.i_exe_vld          = 1'b0;
      bus.i_exe_sqIdx        = '0;
      bus.i_exe_addr         = '0;
      bus.i_exe_data         = '0;
      bus.i_exe_mask         = '0;
      bus.i_commit_vld       = 1'b0;
      bus.i_committed_robIdx = '0;
      bus.i_squash_vld       = 1'b0;
      bus.i_dc_req_rdy       = 1'b0;
`ifdef STORE_QUEUE_FWD_EN
      bus.i_ld_vld           = 1'b0;
      bus.i_ld_addr          = '0;
      bus.i_ld_robIdx        = '0;
`endif
   endtask

   // One clock: drive, sample at negedge against the model, advance the model, step past posedge.
   task automatic cycle(input logic [3:0] req, input bit exe, input bit cmt, input logic [6:0] crob,
                        input bit squash, input bit rdy);
      int  w;
      int  occ;
      bit  can_m;
      bit  go;
      st_t st;
      w = -1;
      bus.i_enq_vld = (req != 4'h0);
      bus.i_enq_req = req;
      for (int k = 0; k < ENQW; k++)
         bus.i_enq_robIdx[k] = next_rob + 7'(k);
      if (exe)
         foreach (pend[i])
            if (!pend[i].written && w < 0)
               w = i;
      if (w >= 0) begin
         bus.i_exe_vld   = 1'b1;
         bus.i_exe_sqIdx = pend[w].sq;
         bus.i_exe_addr  = pend[w].addr;
         bus.i_exe_data  = pend[w].data;
         bus.i_exe_mask  = pend[w].mask;
      end
      bus.i_commit_vld       = cmt;
      bus.i_committed_robIdx = crob;
      bus.i_squash_vld       = squash;
      bus.i_dc_req_rdy       = rdy;

      @(negedge clk);
      s_can   = bus.o_can_enq;
      s_empty = bus.o_empty;
      s_vld   = bus.o_dc_req_vld;
      occ     = expq.size() + pend.size();
      can_m   = (DEPTH - occ) >= ENQW;
      check("can_enq", 64'(s_can), 64'(can_m));
      check("empty", 64'(s_empty), 64'(occ == 0));
      check("dc_req_vld", 64'(s_vld), 64'(expq.size() != 0));
      check("alloc_sqIdx0", 64'(bus.o_alloc_sqIdx[0]), 64'(m_tail));
      if (rdy && expq.size() != 0) begin
         check("dc_addr", bus.o_dc_addr, expq[0].addr);
         check("dc_data", bus.o_dc_data, expq[0].data);
         check("dc_mask", 64'(bus.o_dc_mask), 64'(expq[0].mask));
         void'(expq.pop_front());
      end
      if (w >= 0 && !squash)
         pend[w].written = 1'b1;
      if (cmt) begin
         go = 1'b1;
         for (int j = 0; j < 4; j++) begin
            if (go && pend.size() > 0 && older_eq(pend[0].rob, crob))
               expq.push_back(pend.pop_front());
            else
               go = 1'b0;
         end
      end
      if (squash) begin
         m_tail = m_tail - 5'(pend.size());
         pend.delete();
      end else if (req != 4'h0 && can_m) begin
         for (int k = 0; k < ENQW; k++) begin
            if (req[k]) begin
               st.rob     = next_rob;
               st.sq      = m_tail;
               st.addr    = 64'h8000_0000 + 64'(serial) * 64'd8;
               st.data    = 64'hC0DE_0000_0000_0000 + 64'(serial) * 64'h0001_0001;
               st.mask    = 8'(serial * 37 + 1);
               st.written = 1'b0;
               pend.push_back(st);
               next_rob++;
               m_tail++;
               serial++;
            end
         end
      end
      @(posedge clk);
      #1;
      clear_inputs();
   endtask

   task automatic model_reset();
      pend.delete();
      expq.delete();
      m_tail = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      check("rst_empty", 64'(bus.o_empty), 64'd1);
      check("rst_dc_vld", 64'(bus.o_dc_req_vld), 64'd0);
      check("rst_can_enq", 64'(bus.o_can_enq), 64'd1);
      for (int k = 0; k < ENQW; k++)
         check($sformatf("rst_alloc%0d", k), 64'(bus.o_alloc_sqIdx[k]), 64'(k));
   endtask

   task automatic wb_all(input bit rdy);
      for (int i = 0; i < 40 && has_unwritten(); i++)
         cycle(4'h0, 1'b1, 1'b0, 7'd0, 1'b0, rdy);
      check("wb_all_done", 64'(has_unwritten()), 64'd0);
   endtask

   task automatic drain_all();
      wb_all(1'b1);
      for (int i = 0; i < 100 && (expq.size() + pend.size()) != 0; i++)
         cycle(4'h0, 1'b0, pend.size() != 0, next_rob - 7'd1, 1'b0, 1'b1);
      check("drain_all_occ", 64'(expq.size() + pend.size()), 64'd0);
      check("drain_all_empty", 64'(bus.o_empty), 64'd1);
   endtask

   vec_t        tbl [12];
   logic [4:0]  sq3;
   logic [63:0] a0, d0;
   logic [6:0]  crob;
`ifdef STORE_QUEUE_FWD_EN
   logic [63:0] data_a, data_b;
   logic [7:0]  mask_a, mask_b;
`endif

   initial begin
      tbl[0]  = '{4'h0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[1]  = '{4'hF, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[2]  = '{4'h0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[3]  = '{4'h0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{4'h0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{4'h0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{4'h0, 1'b0, 1'b1, 7'd3, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{4'h0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[8]  = '{4'h0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[9]  = '{4'h0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[10] = '{4'h0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[11] = '{4'h0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b1, 1'b0};

      rst      = 1'b1;
      next_rob = 7'd0;
      serial   = 0;
      do_reset();

      // Basic flow: 4 stores, writeback, commit robIdx 3, four in-order drains.
      foreach (tbl[i]) begin
         cycle(tbl[i].req, tbl[i].exe, tbl[i].cmt, tbl[i].crob, 1'b0, tbl[i].rdy);
         check($sformatf("tbl%0d_can", i), 64'(s_can), 64'(tbl[i].e_can));
         check($sformatf("tbl%0d_empty", i), 64'(s_empty), 64'(tbl[i].e_empty));
         check($sformatf("tbl%0d_vld", i), 64'(s_vld), 64'(tbl[i].e_vld));
      end

      // Fill: can_enq drops at occupancy 13 and returns at 12; then fill to 16.
      repeat (3) cycle(4'hF, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
      cycle(4'h1, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
      cycle(4'hF, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
      check("occ13_can_enq", 64'(s_can), 64'd0);
      wb_all(1'b0);
      cycle(4'h0, 1'b0, 1'b1, pend[0].rob, 1'b0, 1'b0);
      cycle(4'h0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1);
      check("occ13_pending_can_enq", 64'(s_can), 64'd0);
      check("occ13_pending_vld", 64'(s_vld), 64'd1);
      cycle(4'hF, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
      check("occ12_can_enq", 64'(s_can), 64'd1);
      cycle(4'h0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
      check("occ16_can_enq", 64'(s_can), 64'd0);
      check("occ16_empty", 64'(s_empty), 64'd0);
      drain_all();

      // Commit entry 2 and squash in the same cycle; the enqueue alongside is dropped.
      cycle(4'hF, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
      cycle(4'h3, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
      wb_all(1'b0);
      sq3 = pend[3].sq;
      cycle(4'h1, 1'b0, 1'b1, pend[2].rob, 1'b1, 1'b0);
      check("squash_tail", 64'(bus.o_alloc_sqIdx[0]), 64'(sq3));
      check("squash_vld", 64'(bus.o_dc_req_vld), 64'd1);
      repeat (8) cycle(4'h0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1);
      check("squash_drained_empty", 64'(bus.o_empty), 64'd1);

      // Stall with rdy low for 5 cycles while a squash hits; payload must hold.
      cycle(4'h3, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
      wb_all(1'b0);
      cycle(4'h1, 1'b0, 1'b1, pend[1].rob, 1'b0, 1'b0);
      a0 = bus.o_dc_addr;
      d0 = bus.o_dc_data;
      check("hold_start_vld", 64'(bus.o_dc_req_vld), 64'd1);
      for (int i = 0; i < 5; i++) begin
         cycle(4'h0, 1'b0, 1'b0, 7'd0, i == 2, 1'b0);
         check($sformatf("hold%0d_vld", i), 64'(bus.o_dc_req_vld), 64'd1);
         check($sformatf("hold%0d_addr", i), bus.o_dc_addr, a0);
         check($sformatf("hold%0d_data", i), bus.o_dc_data, d0);
      end
      drain_all();

      // Wrap: 40 stores with robIdx crossing the flip boundary.
      next_rob = 7'd50;
      for (int b = 0; b < 10; b++) begin
         cycle(4'hF, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1);
         repeat (4) cycle(4'h0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b1);
         crob = next_rob - 7'd1;
         cycle(4'h0, 1'b0, 1'b1, crob, 1'b0, 1'b1);
      end
      check("wrap_rob_flipped", 64'(next_rob), 64'd90);
      drain_all();

`ifdef STORE_QUEUE_FWD_EN
      // Forwarding: robIdx 2 -> A @0x1000, robIdx 3 -> other addr, robIdx 4 -> B @0x1000.
      next_rob = 7'd2;
      cycle(4'h7, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
      data_a = 64'hAAAA_0000_1111_2222;
      data_b = 64'hBBBB_3333_4444_5555;
      pend[0].addr = 64'h1000;
      pend[0].data = data_a;
      pend[1].addr = 64'h2000;
      pend[2].addr = 64'h1000;
      pend[2].data = data_b;
      mask_a = pend[0].mask;
      mask_b = pend[2].mask;
      wb_all(1'b0);
      bus.i_ld_vld    = 1'b1;
      bus.i_ld_addr   = 64'h1004;
      bus.i_ld_robIdx = 7'd5;
      #1;
      check("fwd_r5_hit", 64'(bus.o_fwd_hit), 64'd1);
      check("fwd_r5_data", bus.o_fwd_data, data_b);
      check("fwd_r5_mask", 64'(bus.o_fwd_mask), 64'(mask_b));
      bus.i_ld_robIdx = 7'd3;
      #1;
      check("fwd_r3_hit", 64'(bus.o_fwd_hit), 64'd1);
      check("fwd_r3_data", bus.o_fwd_data, data_a);
      check("fwd_r3_mask", 64'(bus.o_fwd_mask), 64'(mask_a));
      bus.i_ld_robIdx = 7'd1;
      #1;
      check("fwd_r1_hit", 64'(bus.o_fwd_hit), 64'd0);
      check("fwd_r1_data", bus.o_fwd_data, 64'd0);
      bus.i_ld_vld    = 1'b0;
      bus.i_ld_robIdx = 7'd5;
      #1;
      check("fwd_novld_hit", 64'(bus.o_fwd_hit), 64'd0);
      check("fwd_novld_mask", 64'(bus.o_fwd_mask), 64'd0);
      clear_inputs();
      drain_all();
`endif

      // Reset during a pending drain discards committed entries.
      cycle(4'h3, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
      wb_all(1'b0);
      cycle(4'h0, 1'b0, 1'b1, pend[1].rob, 1'b0, 1'b0);
      check("pre_rst_vld", 64'(bus.o_dc_req_vld), 64'd1);
      do_reset();
      cycle(4'h0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1);
      check("post_rst_vld", 64'(s_vld), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
